load_extend_ctrl: RTL and testbench
===================================

Name: load_extend_ctrl

Overview:
Sequences one RV32I load at a time between the LSU issue stage, the data-memory port and the writeback stage.
- Accepts a load request and issues the memory read.
- Waits for the read data, with an optional timeout.
- Selects the byte, halfword or word lane, then sign- or zero-extends it to XLEN.
- Holds the result until writeback accepts it.
- Misaligned loads, illegal funct3 values, memory errors and timeouts return as error responses instead of data.

Parameters:
XLEN, 32, data width of the memory read data and the writeback data
ADDR_WIDTH, 32, width of the load address
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT; 0 disables the timeout

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  load request valid
req_ready  output  1  block can accept a request
req_funct3  input  3  RV32I load funct3
req_addr  input  ADDR_WIDTH  byte address
req_rd  input  5  destination register
mem_req_valid  output  1  memory read request valid
mem_req_ready  input  1  memory accepts the request
mem_req_addr  output  ADDR_WIDTH  word-aligned address ({req_addr[ADDR_WIDTH-1:2],2'b00})
mem_rvalid  input  1  read data valid
mem_rdata  input  XLEN  read word
mem_err  input  1  bus error, qualified by mem_rvalid
wb_valid  output  1  result valid
wb_ready  input  1  writeback accepts the result
wb_data  output  XLEN  extended load data; 0 when wb_err=1
wb_rd  output  5  destination register
wb_err  output  1  load faulted

Behaviour:
- Reset (asynchronous, any state): state=IDLE; req_ready=1 once reset is released; all other outputs 0; timeout counter 0; latched funct3, addr and rd cleared.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch funct3, addr and rd, then check the request.
  - Illegal funct3 (011, 110, 111) -> RESP with err.
  - LH/LHU with addr[0]=1 -> RESP with err.
  - LW with addr[1:0]!=0 -> RESP with err.
  - Otherwise -> REQ.
  - An errored request never asserts mem_req_valid.
- REQ: mem_req_valid=1 and mem_req_addr held stable until mem_req_ready; on mem_req_valid&mem_req_ready -> WAIT, counter cleared.
- WAIT: counter increments every cycle.
  - mem_rvalid=1 -> RESP. If mem_err, err=1 and data=0; otherwise data=extended lane.
  - Counter reaches TIMEOUT_CYCLES-1 with no mem_rvalid (TIMEOUT_CYCLES>0) -> RESP with err.
  - mem_rvalid in the same cycle as timeout: the data wins.
- RESP: wb_valid=1; wb_data, wb_rd and wb_err held stable until wb_ready. On wb_valid&wb_ready -> IDLE. A new request is accepted in the following cycle, not the same cycle.
- mem_rvalid outside WAIT is ignored; a late response after a timeout is dropped.
- req_ready=0 in all states except IDLE; req_valid is ignored there.
- Lane select and extension:
  - LB/LBU: byte addr[1:0].
  - LH/LHU: half addr[1].
  - LB/LH: replicate bit 7/15.
  - LBU/LHU: zero fill.
  - LW: pass-through.
- Latency, no backpressure: request accepted in cycle N -> mem_req_valid in N+1 -> with 1-cycle memory, data at N+3 -> wb_valid at N+4.
- Error path latency: request accepted in N -> wb_valid in N+1.

Decomposition:
- Shared package riscv_pkg:
  - Load funct3 localparams (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101).
  - FSM state enum ld_state_t {IDLE, REQ, WAIT, RESP}.
- One combinational sub-module load_data_extend (inputs funct3, addr[1:0], word; output XLEN data), reused by any future store-forwarding path.

Test Plan:
- LB, addr=0x1003, mem_rdata=0x80FF_1234 -> wb_data=0xFFFF_FF80, wb_err=0, wb_valid 4 cycles after acceptance.
- LHU, addr=0x2002, mem_rdata=0xBEEF_0001 -> wb_data=0x0000_BEEF; LH, same inputs -> wb_data=0xFFFF_BEEF.
- LW, addr=0x3001 -> wb_err=1, wb_data=0, mem_req_valid never asserted, wb_valid 1 cycle after acceptance.
- mem_req_ready held low for 5 cycles, then wb_ready held low for 3 cycles -> mem_req_addr stable throughout REQ; wb outputs stable throughout RESP; req_ready=0 until return to IDLE.
- TIMEOUT_CYCLES=4, no mem_rvalid -> wb_err=1 after 4 WAIT cycles; a late mem_rvalid is ignored and the next LW returns correct data.
- rst_n asserted low while in WAIT -> all outputs 0 immediately; after release, req_ready=1 and a fresh LBU completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load definitions: funct3 encodings, the load sequencer state
// type and the request legality check used before any memory traffic.
package riscv_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } ld_state_t;

  // A load faults before issue when funct3 is not a load encoding or the
  // address is not naturally aligned for the access size.
  function automatic logic load_fault(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic fault;
    fault = 1'b0;
    case (funct3)
      LB, LBU: fault = 1'b0;
      LH, LHU: fault = addr_lo[0];
      LW:      fault = (addr_lo != 2'b00);
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/load_data_extend.sv
// Combinational lane select and sign/zero extension of a loaded RV32 word.
// Kept standalone so a store-forwarding path can reuse the same extender.
module load_data_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte/halfword, then extend according to funct3.
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    data      = {XLEN{1'b0}};

    case (addr_lo)
      2'b00:   byte_lane = word[7:0];
      2'b01:   byte_lane = word[15:8];
      2'b10:   byte_lane = word[23:16];
      2'b11:   byte_lane = word[31:24];
      default: byte_lane = 8'h00;
    endcase

    if (addr_lo[1]) begin
      half_lane = word[31:16];
    end else begin
      half_lane = word[15:0];
    end

    case (funct3)
      LB:      data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LBU:     data = {{(XLEN-8){1'b0}}, byte_lane};
      LH:      data = {{(XLEN-16){half_lane[15]}}, half_lane};
      LHU:     data = {{(XLEN-16){1'b0}}, half_lane};
      LW:      data = word;
      default: data = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/load_extend_ctrl.sv
// Single-outstanding RV32I load sequencer: accepts a request, issues the
// word-aligned memory read, waits (optionally bounded) for data, extends the
// addressed lane and holds the result until writeback takes it.
module load_extend_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [4:0]            req_rd,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_err,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [XLEN-1:0]       wb_data,
  output logic [4:0]            wb_rd,
  output logic                  wb_err
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; a zero timeout disables it.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  ld_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [4:0]            rd_q, rd_d;

  logic                  req_ready_q, req_ready_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic                  wb_err_q, wb_err_d;

  logic [XLEN-1:0]       ext_data;
  logic                  timeout_hit;

  load_data_extend #(
    .XLEN(XLEN)
  ) u_extend (
    .funct3 (funct3_q),
    .addr_lo(addr_q[1:0]),
    .word   (mem_rdata),
    .data   (ext_data)
  );

  assign timeout_hit = TO_EN && (cnt_q == CNT_MAX);

  // Next-state, request latching and result capture; outputs are derived
  // from the next state so every port is driven straight from a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_err_d  = wb_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          rd_d     = req_rd;
          if (load_fault(req_funct3, req_addr[1:0])) begin
            // Faulting requests skip the bus entirely.
            state_d   = RESP;
            wb_data_d = {XLEN{1'b0}};
            wb_rd_d   = req_rd;
            wb_err_d  = 1'b1;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = REQ;
        end
      end

      WAIT: begin
        // Data arriving on the timeout cycle still wins.
        if (mem_rvalid) begin
          state_d  = RESP;
          wb_rd_d  = rd_q;
          wb_err_d = mem_err;
          if (mem_err) begin
            wb_data_d = {XLEN{1'b0}};
          end else begin
            wb_data_d = ext_data;
          end
        end else if (timeout_hit) begin
          state_d   = RESP;
          wb_rd_d   = rd_q;
          wb_err_d  = 1'b1;
          wb_data_d = {XLEN{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      RESP: begin
        if (wb_ready) begin
          state_d   = IDLE;
          wb_data_d = {XLEN{1'b0}};
          wb_rd_d   = 5'd0;
          wb_err_d  = 1'b0;
        end else begin
          state_d = RESP;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d     = (state_d == IDLE);
    mem_req_valid_d = (state_d == REQ);
    wb_valid_d      = (state_d == RESP);
    if (state_d == REQ) begin
      mem_req_addr_d = {addr_d[ADDR_WIDTH-1:2], 2'b00};
    end else begin
      mem_req_addr_d = {ADDR_WIDTH{1'b0}};
    end
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= {CNT_W{1'b0}};
      funct3_q        <= 3'b000;
      addr_q          <= {ADDR_WIDTH{1'b0}};
      rd_q            <= 5'd0;
      req_ready_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= {ADDR_WIDTH{1'b0}};
      wb_valid_q      <= 1'b0;
      wb_data_q       <= {XLEN{1'b0}};
      wb_rd_q         <= 5'd0;
      wb_err_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      funct3_q        <= funct3_d;
      addr_q          <= addr_d;
      rd_q            <= rd_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      wb_valid_q      <= wb_valid_d;
      wb_data_q       <= wb_data_d;
      wb_rd_q         <= wb_rd_d;
      wb_err_q        <= wb_err_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign wb_rd         = wb_rd_q;
  assign wb_err        = wb_err_q;

endmodule

// File: tb/tb_load_extend_ctrl.sv
// Self-checking bench for load_extend_ctrl: directed test-plan cases plus
// randomized loads compared against an arithmetic reference model.
module tb_load_extend_ctrl;

  localparam int XLEN = 32;
  localparam int AW   = 32;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_funct3 = 3'b000;
  logic [AW-1:0]   req_addr = '0;
  logic [4:0]      req_rd = 5'd0;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_rvalid = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            mem_err = 1'b0;
  logic            wb_valid;
  logic            wb_ready = 1'b0;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_rd;
  logic            wb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_extend_ctrl #(.XLEN(XLEN), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd), .wb_err(wb_err)
  );

  // Reference: does this request fault before reaching memory?
  function automatic bit ref_fault(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        return 1'b1;
    endcase
    return (addr % size) != 0;
  endfunction

  // Reference: value delivered for a good load of 'word' at 'addr'.
  function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
    int size;
    bit sgn;
    logic [31:0] mask;
    logic [31:0] v;
    case (f3)
      3'b000: begin size = 1; sgn = 1'b1; end
      3'b100: begin size = 1; sgn = 1'b0; end
      3'b001: begin size = 2; sgn = 1'b1; end
      3'b101: begin size = 2; sgn = 1'b0; end
      3'b010: begin size = 4; sgn = 1'b0; end
      default: return 32'd0;
    endcase
    if (size == 4) return word;
    mask = (32'd1 << (8 * size)) - 32'd1;
    v = (word >> (8 * (addr % 4))) & mask;
    if (sgn && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  // Drive one load through the DUT acting as LSU, memory and writeback, and
  // report what was observed. Cycle 1 is the cycle after acceptance.
  task automatic run_load(
    input  logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
    input  logic [31:0] word, input bit merr,
    input  int req_stall, input int mem_lat, input int wb_stall, input bit respond,
    output logic [31:0] o_data, output bit o_err, output logic [4:0] o_rd, output int o_lat,
    output bit o_mreq, output bit o_addr_bad, output bit o_wb_unstable,
    output bit o_ready_bad, output bit o_hung);
    int cyc, cd, rs, ws, guard;
    bit hs, sent, done, seen_wb, hs_now, wb_hs;
    o_data = '0; o_err = 1'b0; o_rd = '0; o_lat = 0;
    o_mreq = 1'b0; o_addr_bad = 1'b0; o_wb_unstable = 1'b0; o_ready_bad = 1'b0;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
    req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0; cd = 0; hs = 0; sent = 0; done = 0; seen_wb = 0;
    rs = req_stall; ws = wb_stall;
    while (!done && cyc < 100) begin
      cyc++;
      // Stray requests while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom); req_addr = $urandom; req_rd = 5'($urandom);
      if (req_ready !== 1'b0) o_ready_bad = 1'b1;
      mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
      if (mem_req_valid === 1'b1) begin
        o_mreq = 1'b1;
        if (mem_req_addr !== {addr[31:2], 2'b00}) o_addr_bad = 1'b1;
        mem_req_ready = (rs == 0);
        if (rs > 0) rs--;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_err = 1'($urandom_range(0, 1));
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end
      if (hs && !sent) begin
        if (cd == 0) begin
          if (respond) begin mem_rvalid = 1'b1; mem_rdata = word; mem_err = merr; end
          sent = 1'b1;
        end else begin
          cd--;
        end
      end
      if (wb_valid === 1'b1) begin
        if (!seen_wb) begin
          seen_wb = 1'b1; o_lat = cyc; o_data = wb_data; o_err = wb_err; o_rd = wb_rd;
        end else if (wb_data !== o_data || wb_err !== o_err || wb_rd !== o_rd) begin
          o_wb_unstable = 1'b1;
        end
        wb_ready = (ws == 0);
        if (ws > 0) ws--;
        // Late / stray read data while holding the result.
        mem_rvalid = respond ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_err = 1'($urandom_range(0, 1));
      end else begin
        wb_ready = 1'($urandom_range(0, 1));
      end
      hs_now = (mem_req_valid === 1'b1) && mem_req_ready;
      wb_hs = (wb_valid === 1'b1) && wb_ready;
      @(posedge clk); #1;
      if (hs_now) begin hs = 1'b1; cd = mem_lat; end
      if (wb_hs) done = 1'b1;
    end
    req_valid = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; wb_ready = 1'b0;
    o_hung = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #2; rst_n = 1'b0; #1;
    checks++; if ({req_ready, mem_req_valid, wb_valid, wb_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {req_ready, mem_req_valid, wb_valid, wb_err}); end
    checks++; if (mem_req_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_req_addr); end
    checks++; if (wb_data !== 32'd0 || wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb: got data %h rd %0d expected 0", wb_data, wb_rd); end
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    checks++; if ({mem_req_valid, wb_valid} !== 2'b00) begin errors++; $display("FAIL reset_release_idle: got %b expected 00", {mem_req_valid, wb_valid}); end
  endtask

  task automatic test_directed();
    logic [31:0] d; bit e, m, ab, wu, rb, hg; logic [4:0] r; int l;
    run_load(3'b000, 32'h1003, 5'd7, 32'h80FF_1234, 1'b0, 0, 1, 0, 1'b1, d, e, r, l, m, ab, wu, rb, hg);
    checks++; if (d !== 32'hFFFF_FF80 || e !== 1'b0 || r !== 5'd7) begin errors++; $display("FAIL lb_result: got %h err %b rd %0d expected ffffff80 err 0 rd 7", d, e, r); end
    checks++; if (l !== 4 || hg) begin errors++; $display("FAIL lb_latency: got %0d expected 4", l); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lb_ready_after: got %b expected 1", req_ready); end
    run_load(3'b101, 32'h2002, 5'd9, 32'hBEEF_0001, 1'b0, 0, 1, 0, 1'b1, d, e, r, l, m, ab, wu, rb, hg);
    checks++; if (d !== 32'h0000_BEEF || e !== 1'b0) begin errors++; $display("FAIL lhu_result: got %h err %b expected 0000beef err 0", d, e); end
    run_load(3'b001, 32'h2002, 5'd10, 32'hBEEF_0001, 1'b0, 0, 1, 0, 1'b1, d, e, r, l, m, ab, wu, rb, hg);
    checks++; if (d !== 32'hFFFF_BEEF || e !== 1'b0) begin errors++; $display("FAIL lh_result: got %h err %b expected ffffbeef err 0", d, e); end
    run_load(3'b010, 32'h3001, 5'd11, 32'h1234_5678, 1'b0, 0, 1, 0, 1'b1, d, e, r, l, m, ab, wu, rb, hg);
    checks++; if (d !== 32'd0 || e !== 1'b1 || r !== 5'd11) begin errors++; $display("FAIL lw_misaligned: got %h err %b rd %0d expected 0 err 1 rd 11", d, e, r); end
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL lw_misaligned_nomem: got mem_req_valid seen %b expected 0", m); end
    checks++; if (l !== 1) begin errors++; $display("FAIL lw_misaligned_latency: got %0d expected 1", l); end
    run_load(3'b100, 32'h5001, 5'd12, 32'h0000_A500, 1'b1, 0, 0, 0, 1'b1, d, e, r, l, m, ab, wu, rb, hg);
    checks++; if (d !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL mem_err: got %h err %b expected 0 err 1", d, e); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; bit e, m, ab, wu, rb, hg; logic [4:0] r; int l;
    run_load(3'b010, 32'h0000_4000, 5'd3, 32'hCAFE_F00D, 1'b0, 5, 1, 3, 1'b1, d, e, r, l, m, ab, wu, rb, hg);
    checks++; if (d !== 32'hCAFE_F00D || e !== 1'b0) begin errors++; $display("FAIL bp_result: got %h err %b expected cafef00d err 0", d, e); end
    checks++; if (ab) begin errors++; $display("FAIL bp_addr_stable: got unstable or wrong mem_req_addr expected 00004000"); end
    checks++; if (wu) begin errors++; $display("FAIL bp_wb_stable: got changing wb outputs expected stable"); end
    checks++; if (rb) begin errors++; $display("FAIL bp_ready_low: got req_ready=1 while busy expected 0"); end
    checks++; if (l !== 9) begin errors++; $display("FAIL bp_latency: got %0d expected 9", l); end
  endtask

  task automatic test_timeout();
    logic [31:0] d; bit e, m, ab, wu, rb, hg; logic [4:0] r; int l;
    run_load(3'b010, 32'h0000_6000, 5'd4, 32'h1111_2222, 1'b0, 0, 0, 2, 1'b0, d, e, r, l, m, ab, wu, rb, hg);
    checks++; if (d !== 32'd0 || e !== 1'b1 || r !== 5'd4) begin errors++; $display("FAIL timeout_result: got %h err %b rd %0d expected 0 err 1 rd 4", d, e, r); end
    checks++; if (l !== 2 + TO) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", l, 2 + TO); end
    checks++; if (wu) begin errors++; $display("FAIL timeout_late_rvalid: got wb outputs changed expected stable"); end
    run_load(3'b010, 32'h0000_6004, 5'd5, 32'h3333_4444, 1'b0, 0, 1, 0, 1'b1, d, e, r, l, m, ab, wu, rb, hg);
    checks++; if (d !== 32'h3333_4444 || e !== 1'b0) begin errors++; $display("FAIL after_timeout_lw: got %h err %b expected 33334444 err 0", d, e); end
    // Data in the final WAIT cycle beats the timeout.
    run_load(3'b000, 32'h0000_6001, 5'd6, 32'h0000_7F00, 1'b0, 0, TO - 1, 0, 1'b1, d, e, r, l, m, ab, wu, rb, hg);
    checks++; if (d !== 32'h0000_007F || e !== 1'b0 || l !== 2 + TO) begin errors++; $display("FAIL timeout_data_wins: got %h err %b lat %0d expected 0000007f err 0 lat %0d", d, e, l, 2 + TO); end
  endtask

  task automatic test_random();
    logic [31:0] d, addr, word, exp_d; bit e, m, ab, wu, rb, hg, merr, flt, exp_e; logic [4:0] r, rd;
    logic [2:0] f3; int l, rs, ml, ws, exp_l;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom); addr = $urandom; rd = 5'($urandom); word = $urandom;
      merr = ($urandom_range(0, 7) == 0);
      rs = $urandom_range(0, 3); ml = $urandom_range(0, TO - 1); ws = $urandom_range(0, 2);
      run_load(f3, addr, rd, word, merr, rs, ml, ws, 1'b1, d, e, r, l, m, ab, wu, rb, hg);
      flt = ref_fault(f3, addr);
      exp_e = flt || merr;
      exp_d = exp_e ? 32'd0 : ref_data(f3, addr, word);
      exp_l = flt ? 1 : 3 + rs + ml;
      checks++; if (d !== exp_d || e !== exp_e || r !== rd) begin errors++; $display("FAIL rand_result[%0d]: f3=%b addr=%h got %h err %b rd %0d expected %h err %b rd %0d", i, f3, addr, d, e, r, exp_d, exp_e, rd); end
      checks++; if (l !== exp_l || hg) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, l, exp_l); end
      checks++; if (m !== !flt || ab) begin errors++; $display("FAIL rand_mem_req[%0d]: got seen %b addr_bad %b expected seen %b addr_bad 0", i, m, ab, !flt); end
      checks++; if (wu || rb) begin errors++; $display("FAIL rand_stability[%0d]: got wb_unstable %b ready_busy %b expected 0 0", i, wu, rb); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rand_back_to_back[%0d]: got req_ready %b expected 1", i, req_ready); end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] d; bit e, m, ab, wu, rb, hg; logic [4:0] r; int l;
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_7000; req_rd = 5'd20;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    checks++; if ({req_ready, mem_req_valid, wb_valid} !== 3'b000) begin errors++; $display("FAIL wait_state: got %b expected 000", {req_ready, mem_req_valid, wb_valid}); end
    rst_n = 1'b0; #1;
    checks++; if ({req_ready, mem_req_valid, wb_valid, wb_err, wb_rd, wb_data, mem_req_addr} !== '0) begin errors++; $display("FAIL reset_in_wait: got nonzero outputs expected all 0"); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_in_wait_ready: got %b expected 1", req_ready); end
    run_load(3'b100, 32'h0000_7002, 5'd21, 32'h00C3_0000, 1'b0, 0, 1, 0, 1'b1, d, e, r, l, m, ab, wu, rb, hg);
    checks++; if (d !== 32'h0000_00C3 || e !== 1'b0 || r !== 5'd21 || l !== 4) begin errors++; $display("FAIL post_reset_lbu: got %h err %b rd %0d lat %0d expected 000000c3 err 0 rd 21 lat 4", d, e, r, l); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_timeout();
    test_random();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
